// File: rtl/midi_byte_encoder.sv
// ============================================================================
// Module  : midi_byte_encoder
// Brief   : Re-serialises parsed MIDI messages and SysEx payload bytes into a
//           raw MIDI byte stream with a valid/ready output handshake.
//           Optional feature macro: MIDI_RUNNING_STATUS_EN (running status).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module midi_byte_encoder #(
    parameter int SYSEX_MAX_LEN = 1024,
    parameter int RS_REFRESH    = 16
) (
    input  logic       aclk,
    input  logic       aresetn,
    input  logic [3:0] midi_in_midi_cmd,
    input  logic [3:0] midi_in_midi_ch,
    input  logic [6:0] midi_in_midi_data1,
    input  logic [6:0] midi_in_midi_data2,
    input  logic       midi_in_midi_valid,
    output logic       midi_in_midi_rd,
    output logic       midi_in_midi_busy,
    input  logic [7:0] midi_in_sysex_data,
    input  logic       midi_in_sysex_valid,
    input  logic       midi_in_sysex_last,
    output logic       midi_in_sysex_rd,
    output logic       midi_in_sysex_busy,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready
);

    localparam int LEN_W = $clog2(SYSEX_MAX_LEN + 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_STATUS   = 3'd1,
        S_DATA1    = 3'd2,
        S_DATA2    = 3'd3,
        S_SX_F0    = 3'd4,
        S_SX_DATA  = 3'd5,
        S_SX_F7    = 3'd6,
        S_SX_DRAIN = 3'd7
    } state_t;

    state_t             state_q, state_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic               tx_valid_q, tx_valid_d;
    logic [6:0]         d1_q, d1_d;
    logic [6:0]         d2_q, d2_d;
    logic [1:0]         nbytes_q, nbytes_d;
    logic [LEN_W-1:0]   sx_len_q, sx_len_d;
    logic               sx_term_q, sx_term_d;
    logic               sx_drain_q, sx_drain_d;

    logic [1:0]         w_len;
    logic               w_drop;
    logic [7:0]         w_status;
    logic [LEN_W-1:0]   w_sx_len_inc;
    logic               w_hs;

`ifdef MIDI_RUNNING_STATUS_EN
    localparam int RS_CNT_W = $clog2(RS_REFRESH + 1);
    logic [7:0]          rs_status_q, rs_status_d;
    logic                rs_valid_q, rs_valid_d;
    logic [RS_CNT_W-1:0] rs_cnt_q, rs_cnt_d;
    logic                w_is_chan;
    logic                w_rs_skip;

    assign w_is_chan = midi_in_midi_cmd[3] && (midi_in_midi_cmd != 4'hF);
    assign w_rs_skip = w_is_chan && rs_valid_q && (rs_status_q == w_status) &&
                       (rs_cnt_q < RS_CNT_W'(RS_REFRESH));
`endif

    assign w_status     = {midi_in_midi_cmd, midi_in_midi_ch};
    assign w_sx_len_inc = sx_len_q + LEN_W'(1);
    assign w_hs         = tx_valid_q & tx_ready;

    // Data-byte count per message; w_drop marks messages that are popped but never emitted.
    always_comb begin
        w_len  = 2'd0;
        w_drop = 1'b0;
        case (midi_in_midi_cmd)
            4'h8, 4'h9, 4'hA, 4'hB, 4'hE: w_len = 2'd2;
            4'hC, 4'hD:                   w_len = 2'd1;
            4'hF: begin
                case (midi_in_midi_ch)
                    4'h1, 4'h3:             w_len  = 2'd1;
                    4'h2:                   w_len  = 2'd2;
                    4'h0, 4'h4, 4'h5, 4'h7: w_drop = 1'b1;
                    default:                w_len  = 2'd0;
                endcase
            end
            default: w_drop = 1'b1;
        endcase
    end

    always_comb begin
        state_d          = state_q;
        tx_data_d        = tx_data_q;
        tx_valid_d       = tx_valid_q;
        d1_d             = d1_q;
        d2_d             = d2_q;
        nbytes_d         = nbytes_q;
        sx_len_d         = sx_len_q;
        sx_term_d        = sx_term_q;
        sx_drain_d       = sx_drain_q;
        midi_in_midi_rd  = 1'b0;
        midi_in_sysex_rd = 1'b0;
`ifdef MIDI_RUNNING_STATUS_EN
        rs_status_d      = rs_status_q;
        rs_valid_d       = rs_valid_q;
        rs_cnt_d         = rs_cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (midi_in_midi_valid) begin
                    midi_in_midi_rd = 1'b1;
                    d1_d            = midi_in_midi_data1;
                    d2_d            = midi_in_midi_data2;
                    nbytes_d        = w_len;
                    if (!w_drop) begin
                        state_d    = S_STATUS;
                        tx_valid_d = 1'b1;
                        tx_data_d  = w_status;
`ifdef MIDI_RUNNING_STATUS_EN
                        if (w_rs_skip) begin
                            state_d   = S_DATA1;
                            tx_data_d = {1'b0, midi_in_midi_data1};
                            rs_cnt_d  = rs_cnt_q + RS_CNT_W'(1);
                        end else if (w_is_chan) begin
                            rs_status_d = w_status;
                            rs_valid_d  = 1'b1;
                            rs_cnt_d    = '0;
                        end
`endif
                    end
`ifdef MIDI_RUNNING_STATUS_EN
                    if ((midi_in_midi_cmd == 4'hF) && !midi_in_midi_ch[3]) begin
                        rs_valid_d = 1'b0;
                    end
`endif
                end else if (midi_in_sysex_valid) begin
                    state_d    = S_SX_F0;
                    tx_valid_d = 1'b1;
                    tx_data_d  = 8'hF0;
                    sx_len_d   = '0;
                    sx_term_d  = 1'b0;
                    sx_drain_d = 1'b0;
`ifdef MIDI_RUNNING_STATUS_EN
                    rs_valid_d = 1'b0;
`endif
                end
            end
            S_STATUS: begin
                if (w_hs) begin
                    if (nbytes_q == 2'd0) begin
                        state_d    = S_IDLE;
                        tx_valid_d = 1'b0;
                    end else begin
                        state_d   = S_DATA1;
                        tx_data_d = {1'b0, d1_q};
                    end
                end
            end
            S_DATA1: begin
                if (w_hs) begin
                    if (nbytes_q == 2'd2) begin
                        state_d   = S_DATA2;
                        tx_data_d = {1'b0, d2_q};
                    end else begin
                        state_d    = S_IDLE;
                        tx_valid_d = 1'b0;
                    end
                end
            end
            S_DATA2: begin
                if (w_hs) begin
                    state_d    = S_IDLE;
                    tx_valid_d = 1'b0;
                end
            end
            S_SX_F0: begin
                if (w_hs) begin
                    state_d    = S_SX_DATA;
                    tx_valid_d = 1'b0;
                end
            end
            S_SX_DATA: begin
                // Once the final (or length-limit) byte is popped, stop popping until F7 is queued.
                if (w_hs) begin
                    tx_valid_d = 1'b0;
                    if (sx_term_q) begin
                        state_d    = S_SX_F7;
                        tx_valid_d = 1'b1;
                        tx_data_d  = 8'hF7;
                    end
                end
                if (midi_in_sysex_valid && (!tx_valid_q || tx_ready) && !sx_term_q) begin
                    midi_in_sysex_rd = 1'b1;
                    tx_valid_d       = 1'b1;
                    tx_data_d        = midi_in_sysex_data & 8'h7F;
                    sx_len_d         = w_sx_len_inc;
                    if (midi_in_sysex_last) begin
                        sx_term_d = 1'b1;
                    end else if (w_sx_len_inc == LEN_W'(SYSEX_MAX_LEN)) begin
                        sx_term_d  = 1'b1;
                        sx_drain_d = 1'b1;
                    end
                end
            end
            S_SX_F7: begin
                if (w_hs) begin
                    tx_valid_d = 1'b0;
                    state_d    = sx_drain_q ? S_SX_DRAIN : S_IDLE;
                end
            end
            S_SX_DRAIN: begin
                if (midi_in_sysex_valid) begin
                    midi_in_sysex_rd = 1'b1;
                    if (midi_in_sysex_last) begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q    <= S_IDLE;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            d1_q       <= '0;
            d2_q       <= '0;
            nbytes_q   <= '0;
            sx_len_q   <= '0;
            sx_term_q  <= 1'b0;
            sx_drain_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            d1_q       <= d1_d;
            d2_q       <= d2_d;
            nbytes_q   <= nbytes_d;
            sx_len_q   <= sx_len_d;
            sx_term_q  <= sx_term_d;
            sx_drain_q <= sx_drain_d;
        end
    end

`ifdef MIDI_RUNNING_STATUS_EN
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rs_status_q <= 8'h00;
            rs_valid_q  <= 1'b0;
            rs_cnt_q    <= '0;
        end else begin
            rs_status_q <= rs_status_d;
            rs_valid_q  <= rs_valid_d;
            rs_cnt_q    <= rs_cnt_d;
        end
    end
`endif

    assign tx_data            = tx_data_q;
    assign tx_valid           = tx_valid_q;
    assign midi_in_midi_busy  = (state_q != S_IDLE);
    assign midi_in_sysex_busy = (state_q != S_IDLE) && (state_q != S_SX_DATA);

endmodule

`default_nettype wire

// File: tb/tb_midi_byte_encoder.sv
// ============================================================================
// Module  : tb_midi_byte_encoder
// Brief   : Self-checking bench for midi_byte_encoder (byte-queue model).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_midi_byte_encoder;

    localparam int MAXLEN = 4;
    localparam int RSR    = 2;

    logic       aclk = 1'b0;
    logic       aresetn = 1'b0;
    logic [3:0] midi_cmd = '0, midi_ch = '0;
    logic [6:0] midi_d1 = '0, midi_d2 = '0;
    logic       midi_valid = 1'b0, midi_rd, midi_busy;
    logic [7:0] sx_data = '0;
    logic       sx_valid = 1'b0, sx_last = 1'b0, sx_rd, sx_busy;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready = 1'b1;

    midi_byte_encoder #(.SYSEX_MAX_LEN(MAXLEN), .RS_REFRESH(RSR)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .midi_in_midi_cmd(midi_cmd), .midi_in_midi_ch(midi_ch),
        .midi_in_midi_data1(midi_d1), .midi_in_midi_data2(midi_d2),
        .midi_in_midi_valid(midi_valid), .midi_in_midi_rd(midi_rd),
        .midi_in_midi_busy(midi_busy),
        .midi_in_sysex_data(sx_data), .midi_in_sysex_valid(sx_valid),
        .midi_in_sysex_last(sx_last), .midi_in_sysex_rd(sx_rd),
        .midi_in_sysex_busy(sx_busy),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
    );

    always #5 aclk = ~aclk;

    int n_total = 0, n_pass = 0;
    int hs_count = 0, mrd_count = 0, srd_count = 0, mrd_exp = 0, srd_exp = 0;
    logic [7:0] exp_q[$];
    bit         prev_stall = 1'b0;
    logic [7:0] prev_data = '0;
    bit         throttle = 1'b0;
`ifdef MIDI_RUNNING_STATUS_EN
    bit         m_rs_valid = 1'b0;
    logic [7:0] m_rs_last = '0;
    int         m_rs_skips = 0;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Model: the byte sequence a message must produce, from the MIDI message rules.
    function automatic void model_msg(logic [3:0] cmd, logic [3:0] ch, logic [6:0] d1, logic [6:0] d2);
        int  n = 0;
        bit  drop = 1'b0;
        bit  send_status = 1'b1;
        logic [7:0] status = {cmd, ch};
        if (cmd < 4'h8) drop = 1'b1;
        else if (cmd inside {4'h8, 4'h9, 4'hA, 4'hB, 4'hE}) n = 2;
        else if (cmd inside {4'hC, 4'hD}) n = 1;
        else if (ch inside {4'h0, 4'h4, 4'h5, 4'h7}) drop = 1'b1;
        else if (ch inside {4'h1, 4'h3}) n = 1;
        else if (ch == 4'h2) n = 2;
`ifdef MIDI_RUNNING_STATUS_EN
        if (cmd == 4'hF && ch < 4'h8) m_rs_valid = 1'b0;
        if (!drop && cmd != 4'hF) begin
            if (m_rs_valid && m_rs_last == status && m_rs_skips < RSR) begin
                send_status = 1'b0;
                m_rs_skips++;
            end else begin
                m_rs_valid = 1'b1;
                m_rs_last  = status;
                m_rs_skips = 0;
            end
        end
`endif
        if (drop) return;
        if (send_status) exp_q.push_back(status);
        if (n >= 1) exp_q.push_back({1'b0, d1});
        if (n == 2) exp_q.push_back({1'b0, d2});
    endfunction

    function automatic void model_sysex(logic [7:0] b[0:7], int n);
        exp_q.push_back(8'hF0);
        for (int i = 0; i < n && i < MAXLEN; i++) exp_q.push_back(b[i] & 8'h7F);
        exp_q.push_back(8'hF7);
`ifdef MIDI_RUNNING_STATUS_EN
        m_rs_valid = 1'b0;
`endif
    endfunction

    always @(negedge aclk) begin
        if (aresetn === 1'b1) begin
            if (midi_rd) mrd_count++;
            if (sx_rd) srd_count++;
            if (tx_valid && tx_ready) begin
                hs_count++;
                if (exp_q.size() == 0) check("tx_unexpected_byte", 32'(tx_data), 32'hFFFF_FFFF);
                else check("tx_byte", 32'(tx_data), 32'(exp_q.pop_front()));
            end
            if (prev_stall) check("tx_hold", 32'({tx_valid, tx_data}), 32'({1'b1, prev_data}));
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
        end else begin
            prev_stall = 1'b0;
        end
    end

    always @(posedge aclk) begin
        if (throttle) begin
            #1 tx_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic send_msg(input logic [3:0] cmd, input logic [3:0] ch,
                            input logic [6:0] d1, input logic [6:0] d2, input bit push);
        bit got = 1'b0;
        mrd_exp++;
        @(posedge aclk); #1;
        midi_cmd = cmd; midi_ch = ch; midi_d1 = d1; midi_d2 = d2; midi_valid = 1'b1;
        for (int i = 0; i < 500 && !got; i++) begin
            @(negedge aclk);
            if (midi_rd) got = 1'b1;
        end
        if (!got) check("midi_rd_timeout", 0, 1);
        else if (push) model_msg(cmd, ch, d1, d2);
        @(posedge aclk); #1;
        midi_valid = 1'b0;
    endtask

    task automatic send_sysex(input logic [7:0] b[0:7], input int n, input bit push);
        bit got;
        srd_exp += n;
        if (push) model_sysex(b, n);
        for (int i = 0; i < n; i++) begin
            @(posedge aclk); #1;
            sx_data = b[i]; sx_last = (i == n - 1); sx_valid = 1'b1;
            got = 1'b0;
            for (int k = 0; k < 500 && !got; k++) begin
                @(negedge aclk);
                if (sx_rd) got = 1'b1;
            end
            if (!got) check("sysex_rd_timeout", 0, 1);
            else if (i < MAXLEN) check("sysex_busy_in_data", 32'(sx_busy), 0);
            else check("sysex_busy_in_drain", 32'(sx_busy), 1);
        end
        @(posedge aclk); #1;
        sx_valid = 1'b0; sx_last = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 500; i++) begin
            @(negedge aclk);
            if (exp_q.size() == 0 && !midi_busy && !sx_valid) return;
        end
        check("idle_timeout", 32'(exp_q.size()), 0);
    endtask

    logic [3:0] t_cmd [0:9];
    logic [3:0] t_ch  [0:9];
    logic [6:0] t_d1  [0:9];
    logic [6:0] t_d2  [0:9];
    logic [7:0] sx_a [0:7];
    logic [7:0] sx_b [0:7];
    logic [7:0] sx_c [0:7];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs0, mrd0;
        t_cmd = '{4'hE, 4'hD, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hA, 4'h8, 4'hB};
        t_ch  = '{4'h1, 4'h2, 4'h1, 4'h3, 4'h2, 4'h6, 4'hE, 4'h5, 4'h7, 4'h0};
        t_d1  = '{7'h10, 7'h33, 7'h11, 7'h05, 7'h12, 7'h01, 7'h02, 7'h01, 7'h40, 7'h07};
        t_d2  = '{7'h20, 7'h44, 7'h22, 7'h06, 7'h34, 7'h03, 7'h04, 7'h02, 7'h00, 7'h7F};
        sx_a  = '{8'h7E, 8'h7F, 8'h09, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00};
        sx_b  = '{8'h01, 8'h82, 8'h03, 8'h04, 8'h05, 8'h06, 8'h00, 8'h00};
        sx_c  = '{8'h55, 8'h66, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

        repeat (2) @(posedge aclk);
        #1;
        check("reset_tx_data", 32'(tx_data), 0);
        check("reset_outputs", 32'({tx_valid, midi_rd, sx_rd, midi_busy, sx_busy}), 0);
        @(negedge aclk); #2 aresetn = 1'b1;

        // NoteOn: 93 3C 64 on consecutive cycles after the rd cycle.
        mrd0 = mrd_count;
        send_msg(4'h9, 4'h3, 7'h3C, 7'h64, 1'b1);
        @(negedge aclk); check("noteon_b0", 32'({tx_valid, tx_data}), 32'h193);
        @(negedge aclk); check("noteon_b1", 32'({tx_valid, tx_data}), 32'h13C);
        @(negedge aclk); check("noteon_b2", 32'({tx_valid, tx_data}), 32'h164);
        @(negedge aclk); check("noteon_done", 32'(tx_valid), 0);
        check("noteon_one_rd", 32'(mrd_count - mrd0), 1);

        // ProgChange with a 5-cycle stall on the status byte, then a clock.
        send_msg(4'hC, 4'h0, 7'h05, 7'h00, 1'b1);
        tx_ready = 1'b0;
        repeat (5) begin
            @(negedge aclk); check("stall_hold_c0", 32'({tx_valid, tx_data}), 32'h1C0);
        end
        @(posedge aclk); #1 tx_ready = 1'b1;
        send_msg(4'hF, 4'h8, 7'h00, 7'h00, 1'b1);
        wait_idle();

        // SysEx whose last byte lands exactly on the length limit.
        hs0 = hs_count;
        send_sysex(sx_a, 4, 1'b1);
        wait_idle();
        check("sysex_exact_bytes", 32'(hs_count - hs0), 6);

        // Over-long SysEx: truncated, F7 inserted, remainder drained.
        hs0 = hs_count;
        send_sysex(sx_b, 6, 1'b1);
        wait_idle();
        check("sysex_trunc_bytes", 32'(hs_count - hs0), 6);
        check("sysex_trunc_idle", 32'({midi_busy, sx_busy}), 0);

        // Dropped messages pop but never emit.
        mrd0 = mrd_count;
        hs0  = hs_count;
        send_msg(4'h4, 4'h0, 7'h11, 7'h22, 1'b1);
        send_msg(4'hF, 4'h5, 7'h11, 7'h22, 1'b1);
        repeat (3) begin
            @(negedge aclk); check("drop_no_output", 32'({tx_valid, midi_busy}), 0);
        end
        check("drop_rd_count", 32'(mrd_count - mrd0), 2);
        check("drop_no_bytes", 32'(hs_count - hs0), 0);

        // Message table, first with tx_ready held high, then throttled.
        for (int i = 0; i < 10; i++) send_msg(t_cmd[i], t_ch[i], t_d1[i], t_d2[i], 1'b1);
        wait_idle();
        throttle = 1'b1;
        for (int i = 0; i < 10; i++) send_msg(t_cmd[i], t_ch[i], t_d1[i], t_d2[i], 1'b1);
        wait_idle();
        throttle = 1'b0;
        @(posedge aclk); #1 tx_ready = 1'b1;

        // midi_valid wins over a simultaneous sysex_valid.
        hs0 = hs_count;
        model_msg(4'hC, 4'h2, 7'h11, 7'h00);
        model_sysex(sx_c, 2);
        fork
            send_msg(4'hC, 4'h2, 7'h11, 7'h00, 1'b0);
            send_sysex(sx_c, 2, 1'b0);
        join
        wait_idle();
        check("priority_bytes", 32'(hs_count - hs0), 6);

        // Async reset while DATA1 is being held.
        tx_ready = 1'b0;
        send_msg(4'h9, 4'h3, 7'h3C, 7'h64, 1'b1);
        @(posedge aclk); #1 tx_ready = 1'b1;
        @(posedge aclk); #1 tx_ready = 1'b0;
        @(negedge aclk); check("pre_reset_data1", 32'({tx_valid, tx_data}), 32'h13C);
        #2 aresetn = 1'b0;
        #1;
        check("midreset_tx", 32'({tx_valid, tx_data}), 0);
        check("midreset_ctrl", 32'({midi_rd, sx_rd, midi_busy, sx_busy}), 0);
        exp_q.delete();
`ifdef MIDI_RUNNING_STATUS_EN
        m_rs_valid = 1'b0;
`endif
        @(negedge aclk); #2 aresetn = 1'b1;
        tx_ready = 1'b1;
        @(negedge aclk); check("postreset_idle", 32'({tx_valid, midi_busy}), 0);

        // Four identical NoteOns, then F2, then the NoteOn again.
        hs0 = hs_count;
        for (int i = 0; i < 4; i++) send_msg(4'h9, 4'h0, 7'h40, 7'h50, 1'b1);
        wait_idle();
`ifdef MIDI_RUNNING_STATUS_EN
        check("rs_byte_count", 32'(hs_count - hs0), 10);
`else
        check("rs_byte_count", 32'(hs_count - hs0), 12);
`endif
        send_msg(4'hF, 4'h2, 7'h12, 7'h34, 1'b1);
        send_msg(4'h9, 4'h0, 7'h40, 7'h50, 1'b1);
        @(negedge aclk); check("status_after_f2", 32'({tx_valid, tx_data}), 32'h190);
        wait_idle();

        check("exp_queue_empty", 32'(exp_q.size()), 0);
        check("midi_rd_total", 32'(mrd_count), 32'(mrd_exp));
        check("sysex_rd_total", 32'(srd_count), 32'(srd_exp));
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
